// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between pipeline writeback and
// a small FIFO of MDU results, and tracks which registers still have an MDU write in flight.
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    output logic            wb_stall,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_wd,
    input  logic            mdu_issue,
    input  logic [4:0]      mdu_issue_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    input  logic [4:0]      q_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic            rf_we,
    output logic [4:0]      wR,
    output logic [XLEN-1:0] wD
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

    logic [4:0]       fifo_rd [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_wd [FIFO_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;

    logic             fifo_nonempty;
    logic             pipe_real;
    logic             forced;
    logic             head_grant;
    logic             pipe_grant;
    logic             push;
    logic             pop;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_wd;

    assign fifo_nonempty = (count != '0);
    assign head_rd       = fifo_rd[head_ptr];
    assign head_wd       = fifo_wd[head_ptr];

    // A pipe write to x0 never needs the port, so it leaves the slot free for the FIFO head.
    assign pipe_real  = pipe_we && (pipe_rd != 5'd0);
    assign forced     = !rst && fifo_nonempty && (starve_cnt == STARVE_C);
    assign head_grant = !rst && fifo_nonempty && (forced || !pipe_real);
    assign pipe_grant = !rst && pipe_real && !forced;
    assign wb_stall   = forced;

    // Handshake: a result transfers on a cycle where mdu_valid && mdu_ready; the MDU holds
    // rd/data stable until then. mdu_ready depends only on registered occupancy, so a full
    // FIFO refuses a push even in a cycle where its head drains.
    assign mdu_ready = !rst && (count < DEPTH_C);
    assign push      = mdu_valid && mdu_ready;
    assign pop       = head_grant;

    always_comb begin
        rf_we = 1'b0;
        wR    = '0;
        wD    = '0;
        if (head_grant) begin
            // A head addressed to x0 is consumed silently.
            if (head_rd != 5'd0) begin
                rf_we = 1'b1;
                wR    = head_rd;
                wD    = head_wd;
            end
        end else if (pipe_grant) begin
            rf_we = 1'b1;
            wR    = pipe_rd;
            wD    = pipe_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail_ptr] <= mdu_rd;
            fifo_wd[tail_ptr] <= mdu_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Counts how long the current head has been passed over; saturates at the force point.
    always_ff @(posedge clk) begin
        if (rst || !fifo_nonempty || head_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_C) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Clear first, then set, so a same-cycle issue to the register being retired stays pending.
    always_comb begin
        pending_nxt = pending;
        if (head_grant && (head_rd != 5'd0)) begin
            pending_nxt[head_rd] = 1'b0;
        end
        if (mdu_issue && (mdu_issue_rd != 5'd0)) begin
            pending_nxt[mdu_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs1_busy = !rst && pending[q_rs1];
    assign rs2_busy = !rst && pending[q_rs2];
    assign rd_busy  = !rst && pending[q_rd];

endmodule
